// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the regfile write-port arbiter signals: pipeline W
//               stage, MDU result handshake, regfile port and hazard feedback.
// Revision    : 1.0
// ============================================================================
interface wb_port_arbiter_if;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_result;
    logic        mdu_ready;
    logic        RegWriteRF;
    logic [4:0]  RdRF;
    logic [31:0] WDRF;
    logic        StallWB;
    logic [31:0] pend_mask;

    modport slave (
        input  RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_result,
        output mdu_ready, RegWriteRF, RdRF, WDRF, StallWB, pend_mask
    );

    modport master (
        output RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_result,
        input  mdu_ready, RegWriteRF, RdRF, WDRF, StallWB, pend_mask
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the regfile write port between the W stage (priority)
//               and the MDU, buffering MDU results and requesting W bubbles.
// Revision    : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    wb_port_arbiter_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
    localparam logic [WW-1:0] c_max_wait = WW'(MAX_WAIT);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [WW-1:0]    r_wait;
    logic             r_stall;

    logic             w_pipe_wr;
    logic             w_mdu_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_blocked;
    logic [WW-1:0]    w_wait_inc;
    logic [31:0]      w_pend;

    // Per-slot valid bits make empty/full a single lookup at either pointer.
    assign w_pipe_wr  = bus.RegWriteW && (bus.RdW != 5'd0);
    assign w_mdu_wr   = bus.mdu_valid && (bus.mdu_rd != 5'd0);
    assign w_empty    = !r_vld[r_rd_ptr];
    assign w_full     = r_vld[r_wr_ptr];
    assign w_pop      = !reset && !w_pipe_wr && !w_empty;
    assign w_bypass   = !reset && !w_pipe_wr && w_empty && w_mdu_wr;
    assign w_push     = !reset && w_mdu_wr && !w_full && !w_bypass;
    assign w_blocked  = w_pipe_wr && !w_empty;
    assign w_wait_inc = (r_wait == c_max_wait) ? r_wait : r_wait + 1'b1;

    always_comb begin
        bus.RegWriteRF = 1'b0;
        bus.RdRF       = 5'd0;
        bus.WDRF       = 32'd0;
        if (!reset) begin
            if (w_pipe_wr) begin
                bus.RegWriteRF = 1'b1;
                bus.RdRF       = bus.RdW;
                bus.WDRF       = bus.ResultW;
            end else if (!w_empty) begin
                bus.RegWriteRF = 1'b1;
                bus.RdRF       = r_rd[r_rd_ptr];
                bus.WDRF       = r_data[r_rd_ptr];
            end else if (w_mdu_wr) begin
                bus.RegWriteRF = 1'b1;
                bus.RdRF       = bus.mdu_rd;
                bus.WDRF       = bus.mdu_result;
            end
        end
    end

    always_comb begin
        w_pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend = w_pend | (32'd1 << r_rd[i]);
            end
        end
    end

    assign bus.pend_mask = w_pend;
    assign bus.mdu_ready = !w_full;
    assign bus.StallWB   = r_stall;

    // Payload storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wr_ptr]   <= bus.mdu_rd;
            r_data[r_wr_ptr] <= bus.mdu_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_wait   <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end

            if (w_pop || w_empty) begin
                r_wait <= '0;
            end else if (w_blocked) begin
                r_wait <= w_wait_inc;
            end

            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (w_blocked && (w_wait_inc == c_max_wait)) begin
                r_stall <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench: scripted vectors, corner sequences and
//               random traffic against a queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rw;
        logic [4:0]  rdw;
        logic [31:0] resw;
        bit          mv;
        logic [4:0]  mrd;
        logic [31:0] mres;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          rdy;
        bit          st;
        logic [31:0] pm;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    vec_t tbl [9];

    task automatic drive(input bit rw, input logic [4:0] rdw, input logic [31:0] resw,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mres);
        bus.RegWriteW  = rw;
        bus.RdW        = rdw;
        bus.ResultW    = resw;
        bus.mdu_valid  = mv;
        bus.mdu_rd     = mrd;
        bus.mdu_result = mres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input bit we, input logic [4:0] rd,
                           input logic [31:0] wd, input bit rdy, input bit st,
                           input logic [31:0] pm);
        logic [71:0] act;
        logic [71:0] exp;
        act = {bus.RegWriteRF, bus.RdRF, bus.WDRF, bus.mdu_ready, bus.StallWB, bus.pend_mask};
        exp = {we, rd, wd, rdy, st, pm};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%b rd=%0d wd=%h rdy=%b stall=%b pend=%h, expected we=%b rd=%0d wd=%h rdy=%b stall=%b pend=%h",
                     name, bus.RegWriteRF, bus.RdRF, bus.WDRF, bus.mdu_ready, bus.StallWB,
                     bus.pend_mask, we, rd, wd, rdy, st, pm);
        end
    endtask

    task automatic do_reset();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reference model state
    ent_t        mq [$];
    int          mwait;
    bit          mstall;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        mwait   = 0;
        mstall  = 1'b0;

        // ---- scripted vectors from reset: idle, bypass, conflict, x0 cases ----
        tbl[0] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 32'h0};
        tbl[1] = '{0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF, 1, 0, 32'h0};
        tbl[2] = '{1, 5'd3, 32'h11, 1, 5'd7, 32'h22,       1, 5'd3, 32'h11,       1, 0, 32'h0};
        tbl[3] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        1, 5'd7, 32'h22,       1, 0, 32'h80};
        tbl[4] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 32'h0};
        tbl[5] = '{1, 5'd2, 32'h2,  1, 5'd9, 32'h99,       1, 5'd2, 32'h2,        1, 0, 32'h0};
        tbl[6] = '{1, 5'd0, 32'h55, 1, 5'd0, 32'h77,       1, 5'd9, 32'h99,       1, 0, 32'h200};
        tbl[7] = '{0, 5'd0, 32'h0,  1, 5'd0, 32'h77,       0, 5'd0, 32'h0,        1, 0, 32'h0};
        tbl[8] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 32'h0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rw, tbl[i].rdw, tbl[i].resw, tbl[i].mv, tbl[i].mrd, tbl[i].mres);
            #2;
            chk_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].rd, tbl[i].wd,
                    tbl[i].rdy, tbl[i].st, tbl[i].pm);
            tick();
        end

        // ---- full FIFO: third result held until a pop, in-order drain ----
        do_reset();
        drive(1, 5'd1, 32'hA1, 1, 5'd10, 32'h100); #2;
        chk_all("full_a", 1, 5'd1, 32'hA1, 1, 0, 32'h0); tick();
        drive(1, 5'd1, 32'hA2, 1, 5'd11, 32'h101); #2;
        chk_all("full_b", 1, 5'd1, 32'hA2, 1, 0, 32'h400); tick();
        drive(1, 5'd1, 32'hA3, 1, 5'd12, 32'h102); #2;
        chk_all("full_c", 1, 5'd1, 32'hA3, 0, 0, 32'hC00); tick();
        drive(0, 5'd0, 32'h0, 1, 5'd12, 32'h102); #2;
        chk_all("full_d", 1, 5'd10, 32'h100, 0, 0, 32'hC00); tick();
        drive(0, 5'd0, 32'h0, 1, 5'd12, 32'h102); #2;
        chk_all("full_e", 1, 5'd11, 32'h101, 1, 0, 32'h800); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0); #2;
        chk_all("full_f", 1, 5'd12, 32'h102, 1, 0, 32'h1000); tick();
        #2;
        chk_all("full_g", 0, 5'd0, 32'h0, 1, 0, 32'h0); tick();

        // ---- starvation: StallWB after MAX_WAIT blocked edges ----
        do_reset();
        drive(1, 5'd1, 32'hA, 1, 5'd20, 32'h200); #2;
        chk_all("starve_enq", 1, 5'd1, 32'hA, 1, 0, 32'h0); tick();
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1, 5'd1, 32'hB, 0, 5'd0, 32'h0); #2;
            chk_all($sformatf("starve_wait%0d", i), 1, 5'd1, 32'hB, 1, 0, 32'h100000);
            tick();
        end
        drive(1, 5'd1, 32'hC, 0, 5'd0, 32'h0); #2;
        chk_all("starve_violate", 1, 5'd1, 32'hC, 1, 1, 32'h100000); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0); #2;
        chk_all("starve_drain", 1, 5'd20, 32'h200, 1, 1, 32'h100000); tick();
        #2;
        chk_all("starve_clear", 0, 5'd0, 32'h0, 1, 0, 32'h0); tick();

        // ---- asynchronous reset mid-cycle flushes buffered results ----
        do_reset();
        drive(1, 5'd1, 32'h1, 1, 5'd4, 32'h44); tick();
        drive(1, 5'd1, 32'h1, 1, 5'd6, 32'h66); tick();
        drive(1, 5'd1, 32'h1, 0, 5'd0, 32'h0); #2;
        chk_all("rst_pre", 1, 5'd1, 32'h1, 0, 0, 32'h50);
        #1;
        reset = 1'b1;
        #1;
        chk_all("rst_async", 0, 5'd0, 32'h0, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0); #2;
        chk_all("rst_after0", 0, 5'd0, 32'h0, 1, 0, 32'h0); tick();
        #2;
        chk_all("rst_after1", 0, 5'd0, 32'h0, 1, 0, 32'h0); tick();

        // ---- random traffic against a queue model ----
        do_reset();
        mq.delete();
        mwait  = 0;
        mstall = 1'b0;
        begin
            bit          off_v;
            logic [4:0]  off_rd;
            logic [31:0] off_d;
            bit          rw;
            logic [4:0]  rdw;
            logic [31:0] resw;
            bit          pipe_wr, pop, byp, push, e_we, e_rdy;
            logic [4:0]  e_rd;
            logic [31:0] e_wd, e_pm;
            off_v  = 1'b0;
            off_rd = 5'd0;
            off_d  = 32'd0;
            for (int c = 0; c < 600; c++) begin
                if (!off_v && ($urandom_range(0, 99) < 50)) begin
                    off_v  = 1'b1;
                    off_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    off_d  = $urandom;
                end
                rw   = ($urandom_range(0, 99) < (mstall ? 10 : 65));
                rdw  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                resw = $urandom;
                drive(rw, rdw, resw, off_v, off_rd, off_d);
                #2;

                pipe_wr = rw && (rdw != 5'd0);
                e_rdy   = (mq.size() < DEPTH);
                pop     = 1'b0;
                byp     = 1'b0;
                e_we    = 1'b0;
                e_rd    = 5'd0;
                e_wd    = 32'd0;
                if (pipe_wr) begin
                    e_we = 1'b1; e_rd = rdw; e_wd = resw;
                end else if (mq.size() > 0) begin
                    e_we = 1'b1; e_rd = mq[0].rd; e_wd = mq[0].d; pop = 1'b1;
                end else if (off_v && off_rd != 5'd0) begin
                    e_we = 1'b1; e_rd = off_rd; e_wd = off_d; byp = 1'b1;
                end
                push = off_v && e_rdy && !byp && (off_rd != 5'd0);
                e_pm = 32'd0;
                foreach (mq[k]) e_pm = e_pm | (32'd1 << mq[k].rd);

                chk_all($sformatf("rand%0d", c), e_we, e_rd, e_wd, e_rdy, mstall, e_pm);

                if (pop) begin
                    mwait  = 0;
                    mstall = 1'b0;
                end else if (mq.size() == 0) begin
                    mwait = 0;
                end else begin
                    if (mwait + 1 >= MAX_WAIT) mstall = 1'b1;
                    if (mwait < MAX_WAIT) mwait++;
                end
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back('{off_rd, off_d});
                if (off_v && e_rdy) off_v = 1'b0;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
